// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: synchronous instruction RAM behind a
// valid/ready request/response handshake. Reads have one cycle of latency.
// A 2-entry response FIFO lets the fetch side stall without losing words.
module imem_fetch_responder #(
    parameter int unsigned INS_ADDRESS = 9,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [PC_WIDTH-1:0]    req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_err,
    input  logic                   flush,
    input  logic                   load_en,
    input  logic [INS_ADDRESS-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]  load_data
);

    localparam int unsigned DEPTH   = 2 ** INS_ADDRESS;
    localparam int unsigned ROW_LSB = INS_ADDRESS + 2;

    // Instruction RAM and the registered read of the in-flight request
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   rd_err_q;
    logic                   inflight_q, inflight_d;

    // Response FIFO storage and control
    logic [DATA_WIDTH-1:0]  fifo_data_q [2];
    logic                   fifo_err_q  [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    logic                   addr_err;
    logic [INS_ADDRESS-1:0] word_idx;
    logic [1:0]             occupancy;
    logic                   accept;
    logic                   push;
    logic                   pop;

    // Decode, handshake and next-state computation
    always_comb begin
        addr_err   = (req_addr[1:0] != 2'b00) || ((req_addr >> ROW_LSB) != '0);
        word_idx   = req_addr[INS_ADDRESS+1:2];
        pop        = (count_q != 2'd0) && rsp_ready;
        push       = inflight_q;
        occupancy  = count_q + 2'(inflight_q);
        // A full pipeline can still take a request when the head leaves now
        req_ready  = !reset && !flush &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
        accept     = req_valid && req_ready;

        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (flush) begin
            inflight_d = 1'b0;
            count_d    = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            inflight_d = accept;
            count_d    = count_q + 2'(push) - 2'(pop);
            wr_ptr_d   = wr_ptr_q ^ push;
            rd_ptr_d   = rd_ptr_q ^ pop;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // RAM write port and read port; nonblocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (accept) begin
            rd_err_q <= addr_err;
            if (!addr_err) begin
                rd_data_q <= mem[word_idx];
            end
        end
    end

    // Completed read enters the FIFO one cycle after acceptance
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_data_q[wr_ptr_q] <= rd_err_q ? NOP_WORD : rd_data_q;
            fifo_err_q[wr_ptr_q]  <= rd_err_q;
        end
    end

    assign rsp_valid = (count_q != 2'd0);
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule
